// File: rtl/lcv_mul_seq.sv
// Multi-cycle WxW->2W multiplier: one (W/2+1)x(W/2+1) signed multiply stage
// time-shared over four partial products, accumulated into a 2W-bit result.
module lcv_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inp_valid,
  output logic                 inp_ready,
  input  logic [WIDTH-1:0]     inp_a,
  input  logic [WIDTH-1:0]     inp_b,
  input  logic                 inp_signed,
  output logic                 outp_valid,
  input  logic                 outp_ready,
  output logic [2*WIDTH-1:0]   outp_prod,
  output logic                 outp_busy
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned H  = W / 2;
  localparam int unsigned PW = W + 2;
  localparam int unsigned SW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic [W-1:0]          a_reg, b_reg;
  logic                  sgn_reg;
  logic signed [PW-1:0]  pp_reg;
  logic [SW-1:0]         pp_shift;
  logic                  pp_vld;
  logic [2*W-1:0]        acc;

  logic                  accept_c;
  logic signed [H:0]     a_lo_c, a_hi_c, b_lo_c, b_hi_c;
  logic signed [H:0]     op_x_c, op_y_c;
  logic signed [PW-1:0]  prod_c;
  logic [SW-1:0]         shift_c;
  logic [2*W-1:0]        pp_ext_c;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        accept_c = inp_valid;
        if (inp_valid) state_nxt = ISSUE;
      end
      ISSUE: if (cnt == 2'd3) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  if (outp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand split: low halves always unsigned, high halves follow the mode
  always_comb begin
    a_lo_c = {1'b0, a_reg[H-1:0]};
    b_lo_c = {1'b0, b_reg[H-1:0]};
    a_hi_c = {sgn_reg & a_reg[W-1], a_reg[W-1:H]};
    b_hi_c = {sgn_reg & b_reg[W-1], b_reg[W-1:H]};
    op_x_c = cnt[1] ? a_hi_c : a_lo_c;
    op_y_c = cnt[0] ? b_hi_c : b_lo_c;
    prod_c = PW'(op_x_c) * PW'(op_y_c);
    case (cnt)
      2'd0:    shift_c = '0;
      2'd3:    shift_c = SW'(W);
      default: shift_c = SW'(H);
    endcase
    pp_ext_c = {{(2*W-PW){pp_reg[PW-1]}}, pp_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sgn_reg    <= 1'b0;
      pp_reg     <= '0;
      pp_shift   <= '0;
      pp_vld     <= 1'b0;
      acc        <= '0;
      inp_ready  <= 1'b1;
      outp_valid <= 1'b0;
      outp_busy  <= 1'b0;
    end else begin
      state      <= state_nxt;
      inp_ready  <= (state_nxt == IDLE);
      outp_valid <= (state_nxt == DONE);
      outp_busy  <= (state_nxt != IDLE);

      pp_reg   <= prod_c;
      pp_shift <= shift_c;
      pp_vld   <= (state == ISSUE);

      if (state == ISSUE) cnt <= cnt + 2'd1;

      if (accept_c) begin
        a_reg   <= inp_a;
        b_reg   <= inp_b;
        sgn_reg <= inp_signed;
        cnt     <= '0;
        acc     <= '0;
      end else if (pp_vld) begin
        acc <= acc + (pp_ext_c << pp_shift);
      end
    end
  end

  // Accumulator is visible directly; consumers qualify it with outp_valid
  assign outp_prod = acc;

endmodule

// File: tb/tb_lcv_mul_seq.sv
// Directed and random checks for lcv_mul_seq: latency, corners, back-pressure,
// operand hold, mid-operation reset and an in-order scoreboard.
module tb_lcv_mul_seq;

  logic        clk;
  logic        rst;
  logic        inp_valid;
  logic        inp_ready;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        inp_signed;
  logic        outp_valid;
  logic        outp_ready;
  logic [63:0] outp_prod;
  logic        outp_busy;

  int checks = 0;
  int errors = 0;

  lcv_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_a(inp_a), .inp_b(inp_b), .inp_signed(inp_signed),
    .outp_valid(outp_valid), .outp_ready(outp_ready),
    .outp_prod(outp_prod), .outp_busy(outp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current (IDLE) cycle; returns in cycle T+1
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
    inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
    step();
    inp_valid = 1'b0;
  endtask

  // Cycles from T+1 until outp_valid is seen (T+k), or -1 on timeout
  task automatic wait_valid(output int k);
    k = 1;
    while (!outp_valid && k < 40) begin
      step();
      k++;
    end
    if (!outp_valid) k = -1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic test_reset();
    rst = 1'b1; inp_valid = 1'b0; inp_a = '0; inp_b = '0; inp_signed = 1'b0;
    outp_ready = 1'b1;
    step(); step();
    checks++;
    if (outp_valid !== 1'b0 || outp_busy !== 1'b0 || outp_prod !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b prod=%h, want 0 0 0",
               outp_valid, outp_busy, outp_prod);
    end
    rst = 1'b0;
    step();
    checks++;
    if (inp_ready !== 1'b1 || outp_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b busy=%b, want 1 0", inp_ready, outp_busy);
    end
  endtask

  task automatic test_unsigned_max();
    checks++;
    if (inp_ready !== 1'b1) begin
      errors++;
      $display("FAIL umax_ready_T: got %b want 1", inp_ready);
    end
    outp_ready = 1'b1;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (k == 7) begin
        if (inp_ready !== 1'b1 || outp_valid !== 1'b0) begin
          errors++;
          $display("FAIL umax_T7: ready=%b valid=%b, want 1 0", inp_ready, outp_valid);
        end
      end else if (outp_valid !== (k == 6)) begin
        errors++;
        $display("FAIL umax_valid_T%0d: got %b want %b", k, outp_valid, (k == 6));
      end
      if (k == 6) begin
        checks++;
        if (outp_prod !== 64'hFFFF_FFFE_0000_0001) begin
          errors++;
          $display("FAIL umax_prod: got %h want fffffffe00000001", outp_prod);
        end
      end
      if (k < 7) step();
    end
  endtask

  task automatic test_signed_corners();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic        ts [4];
    logic [63:0] te [4];
    int k;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; ts[0] = 1'b1; te[0] = 64'h0000_0000_0000_0001;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; ts[1] = 1'b1; te[1] = 64'h4000_0000_0000_0000;
    ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001; ts[2] = 1'b1; te[2] = 64'hFFFF_FFFF_8000_0000;
    ta[3] = 32'h8000_0000; tb[3] = 32'h0000_0001; ts[3] = 1'b0; te[3] = 64'h0000_0000_8000_0000;
    outp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept(ta[i], tb[i], ts[i]);
      wait_valid(k);
      checks++;
      if (k !== 6) begin
        errors++;
        $display("FAIL corner%0d_latency: got %0d want 6", i, k);
      end
      checks++;
      if (outp_prod !== te[i]) begin
        errors++;
        $display("FAIL corner%0d_prod: got %h want %h", i, outp_prod, te[i]);
      end
      step();
    end
  endtask

  task automatic test_back_pressure();
    int k;
    outp_ready = 1'b0;
    accept(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_valid(k);
    checks++;
    if (k !== 6) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 6", k);
    end
    for (int c = 6; c <= 9; c++) begin
      if (c == 9) outp_ready = 1'b1;
      checks++;
      if (outp_valid !== 1'b1 || inp_ready !== 1'b0 ||
          outp_prod !== 64'h0B00_EA4E_242D_2080) begin
        errors++;
        $display("FAIL bp_hold_T%0d: valid=%b ready=%b prod=%h, want 1 0 0b00ea4e242d2080",
                 c, outp_valid, inp_ready, outp_prod);
      end
      step();
    end
    checks++;
    if (outp_valid !== 1'b0 || outp_busy !== 1'b0 || inp_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle_T10: valid=%b busy=%b ready=%b, want 0 0 1",
               outp_valid, outp_busy, inp_ready);
    end
  endtask

  task automatic test_operand_hold();
    int k;
    outp_ready = 1'b1;
    inp_a = 32'd3; inp_b = 32'd5; inp_signed = 1'b0; inp_valid = 1'b1;
    step();
    inp_a = 32'hFFFF_FFFF; inp_b = 32'hFFFF_FFFF;
    wait_valid(k);
    checks++;
    if (k !== 6 || outp_prod !== 64'd15) begin
      errors++;
      $display("FAIL hold_first: latency=%0d prod=%h, want 6 000000000000000f", k, outp_prod);
    end
    step();
    checks++;
    if (inp_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_reaccept_T7: ready=%b want 1", inp_ready);
    end
    step();
    inp_valid = 1'b0;
    wait_valid(k);
    checks++;
    if (k !== 6 || outp_prod !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL hold_second: latency=%0d prod=%h, want 6 fffffffe00000001", k, outp_prod);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int k;
    logic seen;
    outp_ready = 1'b1;
    accept(32'd100, 32'd100, 1'b0);
    step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outp_valid !== 1'b0 || outp_busy !== 1'b0 || outp_prod !== 64'd0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b busy=%b prod=%h, want 0 0 0",
               outp_valid, outp_busy, outp_prod);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (outp_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0 || inp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_no_result: seen_valid=%b ready=%b, want 0 1", seen, inp_ready);
    end
    accept(32'd7, 32'd6, 1'b0);
    wait_valid(k);
    checks++;
    if (k !== 6 || outp_prod !== 64'd42) begin
      errors++;
      $display("FAIL midrst_after: latency=%0d prod=%h, want 6 000000000000002a", k, outp_prod);
    end
    step();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] exp_q [$];
    logic [63:0] e;
    int n_acc = 0;
    int n_done = 0;
    int cyc = 0;
    while ((n_done < 1000) && (cyc < 40000)) begin
      inp_valid  = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
      inp_a      = pick_operand();
      inp_b      = pick_operand();
      inp_signed = 1'($urandom_range(0, 1));
      outp_ready = ($urandom_range(0, 2) != 0);
      if (inp_valid && inp_ready) begin
        exp_q.push_back(ref_mul(inp_a, inp_b, inp_signed));
        n_acc++;
      end
      if (outp_valid && outp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_result: prod=%h with no pending request", outp_prod);
        end else begin
          e = exp_q.pop_front();
          if (outp_prod !== e) begin
            errors++;
            $display("FAIL rand_prod #%0d: got %h want %h", n_done, outp_prod, e);
          end
        end
        n_done++;
      end
      step();
      cyc++;
    end
    inp_valid = 1'b0;
    checks++;
    if (n_done !== 1000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count: done=%0d pending=%0d, want 1000 0", n_done, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_back_pressure();
    test_operand_hold();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
